// File: rtl/adder_pkg.sv
// Shared constants and state encoding for the 4-bit adder and its block accumulator.
package adder_pkg;

    localparam int ADDER_DW = 4;
    localparam int ACC_CW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

endpackage

// File: rtl/adder_acc_if.sv
// Sum-in / total-out handshake bundle between the adder stream and the accumulator.
interface adder_acc_if
    import adder_pkg::*;
#(
    parameter int DW = ADDER_DW,
    parameter int CW = ACC_CW
) ();

    localparam int AW = DW + CW;

    logic          in_valid;
    logic [DW-1:0] in_sum;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_acc;
    logic [CW-1:0] out_cnt;
    logic          out_ready;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_acc, out_cnt
    );

endinterface

// File: rtl/adder.sv
// Combinational unsigned adder feeding the accumulator; sum wraps at DW bits.
module adder
    import adder_pkg::*;
#(
    parameter int DW = ADDER_DW
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] s_o
);

    assign s_o = a_i + b_i;

endmodule

// File: rtl/adder_acc.sv
// Accumulates a programmable number of adder sums into one wide total per block.
//
// state | meaning
// IDLE  | waiting for the first beat of a block
// ACC   | accumulating beats until cnt reaches len
// HOLD  | total presented, waiting for downstream
module adder_acc
    import adder_pkg::*;
#(
    parameter int DW = ADDER_DW,
    parameter int CW = ACC_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] cfg_len,
    input  logic          clear,
    output logic          busy,
    adder_acc_if.slave    bus
);

    localparam int AW = DW + CW;

    acc_state_t    state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] cnt_inc;

    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign busy          = (state_q != IDLE);

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;
    assign len_eff  = (cfg_len == '0) ? CW'(1) : cfg_len;
    assign cnt_inc  = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= CW'(1);
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    len_d   = len_eff;
                    acc_d   = {{CW{1'b0}}, bus.in_sum};
                    cnt_d   = CW'(1);
                    state_d = (len_eff == CW'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (in_xfer) begin
                    acc_d = acc_q + {{CW{1'b0}}, bus.in_sum};
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any beat or total transfer in the same cycle.
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

endmodule
